// File: rtl/dcache_req_queue_pkg.sv
// Shared types and sizing constants for the ROB-to-dcache request queue.
// The ROB side uses the depth constants to size its credit counter.
package dcache_req_queue_pkg;

    localparam int DCACHE_REQ_QUEUE_DEPTH   = 4;
    localparam int DCACHE_REQ_QUEUE_DEPTH_W = 2;

    // Request payload as driven by the ROB; the queue treats it as opaque.
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] data;
    } dcache_request_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_e;

endpackage

// File: rtl/sync_fifo_ptrs.sv
// Read/write pointers, occupancy count and the EMPTY/PARTIAL/FULL state machine
// for a synchronous FIFO. The caller guarantees push only when not full and pop only when not empty.
module sync_fifo_ptrs
    import dcache_req_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    output logic [DEPTH_W-1:0] wr_ptr,
    output logic [DEPTH_W-1:0] rd_ptr,
    output logic [DEPTH_W:0]   count,
    output logic               empty,
    output logic               full
);

    localparam logic [DEPTH_W:0] COUNT_MAX  = (DEPTH_W+1)'(DEPTH);
    localparam logic [DEPTH_W:0] COUNT_LAST = (DEPTH_W+1)'(DEPTH - 1);

    occ_state_e state, state_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= OCC_EMPTY;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= OCC_EMPTY;
        end else begin
            if (push) wr_ptr <= wr_ptr + DEPTH_W'(1);
            if (pop)  rd_ptr <= rd_ptr + DEPTH_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (DEPTH_W+1)'(1);
                2'b01:   count <= count - (DEPTH_W+1)'(1);
                default: count <= count;
            endcase
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            OCC_EMPTY: begin
                if (push) state_next = OCC_PARTIAL;
            end
            OCC_PARTIAL: begin
                if (push && !pop && count == COUNT_LAST)
                    state_next = OCC_FULL;
                else if (pop && !push && count == (DEPTH_W+1)'(1))
                    state_next = OCC_EMPTY;
            end
            OCC_FULL: begin
                if (pop && !push) state_next = OCC_PARTIAL;
            end
            default: state_next = OCC_EMPTY;
        endcase
    end

    assign empty = (state == OCC_EMPTY);
    assign full  = (state == OCC_FULL) && (count == COUNT_MAX);

endmodule

// File: rtl/dcache_req_queue.sv
// In-order request queue between ROB retirement and the dcache pipeline; flush drops everything.
// Optional DCACHE_REQ_QUEUE_BYPASS_EN lets a request to an empty queue reach the dcache in the same cycle.
module dcache_req_queue
    import dcache_req_queue_pkg::*;
#(
    parameter int DEPTH   = DCACHE_REQ_QUEUE_DEPTH,
    parameter int DEPTH_W = DCACHE_REQ_QUEUE_DEPTH_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               rob_req_valid,
    input  dcache_request_t    rob_req_info,
    output logic               cache_stage_ready,
    output logic               dcache_req_valid,
    output dcache_request_t    dcache_req_info,
    input  logic               dcache_ready,
    output logic               queue_empty,
    output logic               queue_full,
    output logic [DEPTH_W:0]   queue_count
);

    dcache_request_t    storage [DEPTH];
    logic [DEPTH_W-1:0] wr_ptr;
    logic [DEPTH_W-1:0] rd_ptr;
    logic               accept;
    logic               push;
    logic               pop;

    assign cache_stage_ready = !queue_full && !flush;
    assign accept            = rob_req_valid && cache_stage_ready;
    // Flush drops the head even if the dcache is ready; the dcache sees the same exception.
    assign pop               = !queue_empty && dcache_ready && !flush;

`ifdef DCACHE_REQ_QUEUE_BYPASS_EN
    logic bypass_hit;

    assign bypass_hit       = queue_empty && !flush && rob_req_valid;
    assign push             = accept && !(bypass_hit && dcache_ready);
    assign dcache_req_valid = !queue_empty || bypass_hit;
    assign dcache_req_info  = !queue_empty ? storage[rd_ptr]
                            : (bypass_hit ? rob_req_info : '0);
`else
    assign push             = accept;
    assign dcache_req_valid = !queue_empty;
    assign dcache_req_info  = queue_empty ? '0 : storage[rd_ptr];
`endif

    // NOTE: the payload array has no reset; stale entries are never visible
    // because the output mux forces zero while the queue is empty.
    always_ff @(posedge clock) begin
        if (push) storage[wr_ptr] <= rob_req_info;
    end

    sync_fifo_ptrs #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) u_ptrs (
        .clock  (clock),
        .reset  (reset),
        .flush  (flush),
        .push   (push),
        .pop    (pop),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (queue_count),
        .empty  (queue_empty),
        .full   (queue_full)
    );

endmodule

// File: tb/tb_dcache_req_queue.sv
// Self-checking bench for dcache_req_queue: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_dcache_req_queue;
    import dcache_req_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 2;
`ifdef DCACHE_REQ_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            flush = 1'b0;
    logic            rob_req_valid = 1'b0;
    dcache_request_t rob_req_info = '0;
    logic            cache_stage_ready;
    logic            dcache_req_valid;
    dcache_request_t dcache_req_info;
    logic            dcache_ready = 1'b0;
    logic            queue_empty;
    logic            queue_full;
    logic [DW:0]     queue_count;

    int vectors     = 0;
    int miscompares = 0;

    dcache_req_queue #(.DEPTH(DEPTH), .DEPTH_W(DW)) dut (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .rob_req_valid     (rob_req_valid),
        .rob_req_info      (rob_req_info),
        .cache_stage_ready (cache_stage_ready),
        .dcache_req_valid  (dcache_req_valid),
        .dcache_req_info   (dcache_req_info),
        .dcache_ready      (dcache_ready),
        .queue_empty       (queue_empty),
        .queue_full        (queue_full),
        .queue_count       (queue_count)
    );

    always #5 clock = ~clock;

    function automatic dcache_request_t mk(input logic [7:0] tag);
        dcache_request_t r;
        r = '0;
        if (tag != 8'h00) begin
            r.addr = {24'h100000, tag};
            r.data = {4{tag}};
            r.be   = tag[3:0];
            r.we   = tag[0];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; outputs settle before the next rising edge.
    task automatic apply(input logic f, input logic v, input dcache_request_t info, input logic r);
        @(negedge clock);
        flush         = f;
        rob_req_valid = v;
        rob_req_info  = info;
        dcache_ready  = r;
        #4;
    endtask

    task automatic expect_out(input string tag, input logic v, input dcache_request_t info,
                              input int cnt, input logic rdy);
        check({tag, " valid"}, 128'(dcache_req_valid), 128'(v));
        check({tag, " info"},  128'(dcache_req_info),  128'(info));
        check({tag, " count"}, 128'(queue_count),      128'(cnt));
        check({tag, " ready"}, 128'(cache_stage_ready), 128'(rdy));
        check({tag, " empty"}, 128'(queue_empty),      128'(cnt == 0));
        check({tag, " full"},  128'(queue_full),       128'(cnt == DEPTH));
    endtask

    typedef struct {
        logic       f;
        logic       v;
        logic [7:0] tag;
        logic       r;
        logic       e_v;
        logic [7:0] e_tag;
        int         e_cnt;
        logic       e_rdy;
    } vec_t;

    vec_t tbl [19];
    dcache_request_t model_q [$];

    initial begin
        // Ordering: three pushes while stalled, then three pops in order.
        tbl[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, BYP,  BYP ? 8'h11 : 8'h00, 0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 2, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 3, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 2, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b1};
        // Fill to DEPTH, refuse a 5th, pop frees a slot for the next cycle.
        tbl[7]  = '{1'b0, 1'b1, 8'hA0, 1'b0, BYP,  BYP ? 8'hA0 : 8'h00, 0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 8'hA0, 1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 8'hA0, 2, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 8'hA0, 3, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 8'hA4, 1'b0, 1'b1, 8'hA0, 4, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 8'hA0, 4, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 8'hA4, 1'b0, 1'b1, 8'hA1, 3, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA1, 4, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA2, 3, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA3, 2, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA4, 1, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b1};

        #2;
        expect_out("reset", 1'b0, '0, 0, 1'b1);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 19; i++) begin
            apply(tbl[i].f, tbl[i].v, mk(tbl[i].tag), tbl[i].r);
            expect_out($sformatf("vec%0d", i), tbl[i].e_v, mk(tbl[i].e_tag), tbl[i].e_cnt, tbl[i].e_rdy);
        end

        // Stall stability: head holds for five stalled cycles.
        apply(1'b0, 1'b1, mk(8'h77), 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, '0, 1'b0);
            expect_out($sformatf("stall%0d", i), 1'b1, mk(8'h77), 1, 1'b1);
        end
        apply(1'b0, 1'b0, '0, 1'b1);
        apply(1'b0, 1'b0, '0, 1'b0);
        expect_out("stall_drain", 1'b0, '0, 0, 1'b1);

        // Flush beats push and pop in the same cycle.
        apply(1'b0, 1'b1, mk(8'h31), 1'b0);
        apply(1'b0, 1'b1, mk(8'h32), 1'b0);
        apply(1'b0, 1'b1, mk(8'h33), 1'b0);
        apply(1'b1, 1'b1, mk(8'h44), 1'b1);
        expect_out("flush_cyc", 1'b1, mk(8'h31), 3, 1'b0);
        apply(1'b0, 1'b0, '0, 1'b0);
        expect_out("flush_after", 1'b0, '0, 0, 1'b1);

        // Asynchronous reset with three entries queued.
        apply(1'b0, 1'b1, mk(8'h51), 1'b0);
        apply(1'b0, 1'b1, mk(8'h52), 1'b0);
        apply(1'b0, 1'b1, mk(8'h53), 1'b0);
        @(negedge clock);
        rob_req_valid = 1'b0;
        rob_req_info  = '0;
        #2 reset = 1'b0;
        #1;
        expect_out("async_rst", 1'b0, '0, 0, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        apply(1'b0, 1'b1, mk(8'hA1), 1'b0);
        apply(1'b0, 1'b0, '0, 1'b0);
        expect_out("post_rst", 1'b1, mk(8'hA1), 1, 1'b1);
        apply(1'b0, 1'b0, '0, 1'b1);

        // Same-cycle pass-through only in the bypass build.
        apply(1'b0, 1'b1, mk(8'h5C), 1'b1);
        expect_out("byp_cyc", BYP, BYP ? mk(8'h5C) : '0, 0, 1'b1);
        apply(1'b0, 1'b0, '0, 1'b0);
        expect_out("byp_next", !BYP, BYP ? '0 : mk(8'h5C), BYP ? 0 : 1, 1'b1);
        apply(1'b0, 1'b0, '0, 1'b1);
        apply(1'b0, 1'b0, '0, 1'b0);
        expect_out("byp_drain", 1'b0, '0, 0, 1'b1);

        // Randomized traffic against a queue model; ready bias alternates to reach full and empty.
        model_q.delete();
        for (int i = 0; i < 600; i++) begin
            logic            f;
            logic            v;
            logic            r;
            logic [95:0]     rnd;
            dcache_request_t info;
            logic            e_rdy;
            logic            e_v;
            dcache_request_t e_info;
            int              sz;
            f    = ($urandom_range(0, 39) == 0);
            v    = ($urandom_range(0, 3) != 0);
            r    = ($urandom_range(0, 99) < (((i / 50) % 2) != 0 ? 25 : 80));
            rnd  = {$urandom(), $urandom(), $urandom()};
            info = rnd[$bits(dcache_request_t)-1:0];
            apply(f, v, info, r);

            sz     = model_q.size();
            e_rdy  = (sz < DEPTH) && !f;
            e_v    = (sz > 0) || (BYP && v && !f);
            e_info = (sz > 0) ? model_q[0] : ((BYP && v && !f) ? info : '0);
            expect_out($sformatf("rnd%0d", i), e_v, e_info, sz, e_rdy);

            if (f) begin
                model_q.delete();
            end else if (sz == 0 && BYP && v && r) begin
                // consumed straight through, nothing stored
            end else begin
                if (sz > 0 && r) void'(model_q.pop_front());
                if (v && e_rdy) model_q.push_back(info);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcache_req_queue.md
Name: dcache_req_queue

Overview:
- Responder/receiver for the reorder-buffer-to-data-cache request interface: the same valid / cache_stage_ready / dcache_request_t protocol the writeback stage drives toward the cache.
- Accepts committed memory requests from the ROB and buffers them in an in-order FIFO.
- Presents them to the dcache pipeline with a valid/ready handshake, decoupling ROB retirement from cache stalls.
- Discards all buffered requests on an exception flush.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, at least 2).
- DEPTH_W, 2, log2(DEPTH); pointer width.

Ports:
- clock, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low reset (reset==0 resets).
- flush, in, 1, registered exception flush (same timing as the ROB's invalidate_buffer); drops all queue contents.
- rob_req_valid, in, 1, ROB request valid (req_to_dcache_valid).
- rob_req_info, in, $bits(dcache_request_t), request payload (req_to_dcache_info); opaque to this block.
- cache_stage_ready, out, 1, queue can accept a request this cycle.
- dcache_req_valid, out, 1, head entry presented to the dcache.
- dcache_req_info, out, $bits(dcache_request_t), head payload.
- dcache_ready, in, 1, dcache accepts the head this cycle.
- queue_empty, out, 1, occupancy==0.
- queue_full, out, 1, occupancy==DEPTH.
- queue_count, out, DEPTH_W+1, current occupancy.

Behaviour:
- Reset (reset==0, async):
  - wr_ptr=0, rd_ptr=0, count=0.
  - cache_stage_ready=1 (outputs are derived from state; not gated by reset).
  - dcache_req_valid=0, dcache_req_info=0, queue_empty=1, queue_full=0, queue_count=0.
  - Storage array is not reset; the payload output is forced to 0 when empty.
- Handshakes:
  - Push occurs when rob_req_valid && cache_stage_ready.
  - Pop occurs when dcache_req_valid && dcache_ready.
  - cache_stage_ready = !queue_full && !flush. It is combinational from registered state and flush only, with no path from rob_req_valid.
  - dcache_req_valid = !queue_empty. It must not depend combinationally on dcache_ready.
  - Once dcache_req_valid is asserted, valid and info stay stable until the pop, except on flush.
- Latency: a pushed request is visible on dcache_req_valid the cycle after the push (1 cycle minimum, non-bypass build).
- Ordering: strict FIFO; no reordering or merging.
- Pointers wrap modulo DEPTH. count increments on a push-only cycle, decrements on a pop-only cycle, and is unchanged on a simultaneous push+pop.
- Full: a push and a pop in the same cycle is legal only if not full. When full, ready=0, so a pop just frees a slot for the next cycle.
- Empty: no pop is possible; dcache_req_valid=0.
- Flush has priority over push and pop in the same cycle:
  - Next state is wr_ptr=rd_ptr=0, count=0.
  - The presented head is dropped even if dcache_ready=1 that cycle; the dcache is flushed by the same exception.
  - ROB requests offered during the flush cycle are not accepted (ready=0).
- Reset asserted mid-operation empties the queue asynchronously, and outputs reach their reset values immediately.
- Occupancy state machine (derived from count):
  - EMPTY -> PARTIAL on push.
  - PARTIAL -> FULL when count reaches DEPTH.
  - FULL -> PARTIAL on pop.
  - PARTIAL -> EMPTY on the last pop.
  - Any state -> EMPTY on flush.

Optional Feature:
- Macro: DCACHE_REQ_QUEUE_BYPASS_EN.
- Defined: when the queue is empty and not flushing, rob_req_valid/rob_req_info pass straight through to dcache_req_valid/dcache_req_info in the same cycle.
  - If dcache_ready=1, the request is consumed with no enqueue (0-cycle latency).
  - Otherwise it is enqueued normally.
  - This adds combinational paths rob_req_valid->dcache_req_valid and rob_req_info->dcache_req_info.
- Undefined: latency is always at least 1 cycle and all outputs are registered-state-only (except cache_stage_ready via flush).

Decomposition:
- dcache_request_t comes from the shared soc package/header; this block adds no new typedefs.
- Add DCACHE_REQ_QUEUE_DEPTH and DCACHE_REQ_QUEUE_DEPTH_W constants to soc.vh so the ROB side can size credits.
- One natural sub-module, sync_fifo_ptrs: pointer/count bookkeeping with full/empty. The storage array and bypass mux stay in the top.

Test Plan:
- Reset: drive reset=0 mid-traffic with 3 entries queued -> count=0, dcache_req_valid=0, cache_stage_ready=1 immediately; after release, the first push of payload 0xA1 appears on dcache_req_info the next cycle.
- Ordering: push 0x11, 0x22, 0x33 back-to-back with dcache_ready=0, then hold dcache_ready=1 -> pops 0x11, 0x22, 0x33 in order on 3 consecutive cycles, then queue_empty=1.
- Full and wrap:
  - Push DEPTH=4 entries with dcache_ready=0 -> queue_full=1, cache_stage_ready=0, and a 5th offered request is not accepted.
  - Pop one -> ready=1 the next cycle.
  - Continue 10 push/pop pairs -> data intact across pointer wrap; count stays constant on push+pop cycles.
- Stall stability: with dcache_ready=0 for 5 cycles, the head holds valid=1 and unchanged info throughout.
- Flush: 3 entries queued, flush=1 with rob_req_valid=1 and dcache_ready=1 -> nothing popped or pushed; the next cycle shows count=0, valid=0, ready=1.
- Bypass (macro defined): empty queue, rob_req_valid=1 info=0x5C, dcache_ready=1 -> dcache_req_valid=1 with 0x5C in the same cycle and count stays 0. Without the macro, 0x5C appears one cycle later.
